// File: rtl/max_switch_monitor.sv
// -----------------------------------------------------------------------------
// max_switch_monitor
//
// Windowed monitor for the 1-bit worst-case-switching flag produced by the
// 8-bit max-switching detector. Flagged cycles are counted over windows of
// WINDOW enabled cycles. When a window collects at least THRESH events, a
// registered alarm is raised for HOLD cycles. A saturating lifetime event
// count feeds the power/noise telemetry path.
//
// Parameters:
//   WINDOW  window length in enabled (en=1) cycles, legal 2..256
//   THRESH  events per window that raise the alarm, legal 1..255
//   HOLD    cycles the alarm stays high, legal 1..256
//
// Ports:
//   clk            sole clock, rising edge
//   reset          synchronous, active-high
//   en             qualifies the current cycle for window counting
//   max_switching  worst-case-switching flag, valid every cycle
//   clear          synchronous soft clear (same effect as reset)
//   alarm          high while the FSM is in ALARM (registered)
//   window_done    one-cycle pulse after each completed window (registered)
//   last_count     event count of the most recently completed window
//   total_count    lifetime accepted events, saturating at 65535
//
// Handshake note: there is no valid/ready flow control here. The flag is
// sampled on every edge; en is the only qualifier, and an event is
// "accepted" only when en=1 while the FSM is in COUNT.
//
// FSM:
//   IDLE  : waiting for the first en; events ignored. The en cycle that
//           leaves IDLE is not itself counted.
//   COUNT : accepted cycles advance the window; en=0 freezes everything.
//   ALARM : counts HOLD cycles regardless of en; events ignored.
//
// The FSM state is kept in the named register `state` (type state_t) so a
// bound checker can observe it directly.
// -----------------------------------------------------------------------------
module max_switch_monitor #(
  parameter int WINDOW = 8,
  parameter int THRESH = 3,
  parameter int HOLD   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        max_switching,
  input  logic        clear,
  output logic        alarm,
  output logic        window_done,
  output logic [7:0]  last_count,
  output logic [15:0] total_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_ALARM = 2'd2
  } state_t;

  // Parameter-derived constants, sized to the 8-bit counters. WINDOW-1 and
  // HOLD-1 are at most 255 over the legal ranges, so they always fit.
  localparam logic [7:0]  LAST_CYC  = 8'(WINDOW - 1);
  localparam logic [7:0]  THRESH_V  = 8'(THRESH);
  localparam logic [7:0]  HOLD_INIT = 8'(HOLD - 1);
  localparam logic [7:0]  WIN_MAX   = 8'hFF;
  localparam logic [15:0] TOTAL_MAX = 16'hFFFF;

  state_t      state;
  logic [7:0]  cyc_ctr;
  logic [7:0]  win_ctr;
  logic [7:0]  hold_ctr;

  // Window event count including the current cycle's flag. Saturates at
  // 255 so a long window with THRESH near the top cannot wrap back below
  // the threshold. Only consumed in COUNT on accepted cycles.
  logic [7:0]  win_next;
  logic        total_inc;

  always_comb begin
    win_next  = win_ctr;
    total_inc = 1'b0;
    if (max_switching && (win_ctr != WIN_MAX)) begin
      win_next = win_ctr + 8'd1;
    end
    if (max_switching && (total_count != TOTAL_MAX)) begin
      total_inc = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      // reset has priority over clear, but both return the block to the
      // same all-zero IDLE condition, so a single branch covers both.
      state       <= S_IDLE;
      cyc_ctr     <= 8'd0;
      win_ctr     <= 8'd0;
      hold_ctr    <= 8'd0;
      last_count  <= 8'd0;
      total_count <= 16'd0;
      alarm       <= 1'b0;
      window_done <= 1'b0;
    end else begin
      // window_done is a pulse: low unless this edge ends a window.
      window_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (en) begin
            state   <= S_COUNT;
            cyc_ctr <= 8'd0;
            win_ctr <= 8'd0;
          end
        end

        S_COUNT: begin
          // en=0 leaves every counter untouched: disabled gaps stretch a
          // window in wall-clock time without shortening it.
          if (en) begin
            if (total_inc) begin
              total_count <= total_count + 16'd1;
            end

            if (cyc_ctr == LAST_CYC) begin
              // Window end: the event on this last cycle still counts.
              last_count  <= win_next;
              window_done <= 1'b1;
              cyc_ctr     <= 8'd0;
              win_ctr     <= 8'd0;
              if (win_next >= THRESH_V) begin
                state    <= S_ALARM;
                alarm    <= 1'b1;
                hold_ctr <= HOLD_INIT;
              end
            end else begin
              cyc_ctr <= cyc_ctr + 8'd1;
              win_ctr <= win_next;
            end
          end
        end

        S_ALARM: begin
          // Hold length is fixed in clock cycles; en and the flag are
          // ignored until the last hold cycle, where en picks the exit.
          if (hold_ctr != 8'd0) begin
            hold_ctr <= hold_ctr - 8'd1;
          end else begin
            alarm <= 1'b0;
            if (en) begin
              state   <= S_COUNT;
              cyc_ctr <= 8'd0;
              win_ctr <= 8'd0;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          alarm <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_switch_monitor.sv
module tb_max_switch_monitor;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        max_switching = 1'b0;
  logic        clear = 1'b0;
  logic        alarm;
  logic        window_done;
  logic [7:0]  last_count;
  logic [15:0] total_count;

  max_switch_monitor dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .max_switching (max_switching),
    .clear         (clear),
    .alarm         (alarm),
    .window_done   (window_done),
    .last_count    (last_count),
    .total_count   (total_count)
  );

  // Saturation instance: long window, threshold near the top
  logic        s_reset = 1'b0;
  logic        s_en = 1'b0;
  logic        s_ms = 1'b0;
  logic        s_clear = 1'b0;
  logic        s_alarm;
  logic        s_wd;
  logic [7:0]  s_last;
  logic [15:0] s_total;

  max_switch_monitor #(.WINDOW(256), .THRESH(255), .HOLD(4)) dut_sat (
    .clk           (clk),
    .reset         (s_reset),
    .en            (s_en),
    .max_switching (s_ms),
    .clear         (s_clear),
    .alarm         (s_alarm),
    .window_done   (s_wd),
    .last_count    (s_last),
    .total_count   (s_total)
  );

  // ---------------------------------------------------------------------------
  // Vector table and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        r;
    logic        e;
    logic        m;
    logic        c;
    logic        a;
    logic        w;
    logic [7:0]  l;
    logic [15:0] t;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic v(input logic r, input logic e, input logic m, input logic c,
                   input logic a, input logic w, input logic [7:0] l,
                   input logic [15:0] t);
    vec_t x;
    x.r = r; x.e = e; x.m = m; x.c = c;
    x.a = a; x.w = w; x.l = l; x.t = t;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0d want %0d", name, idx, got, want);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    int cyc;
    logic [15:0] want_t;

    // Table columns: reset, en, ms, clear | alarm, window_done, last, total
    // Expected outputs are those seen just after the edge that samples the row.

    // Reset held 2 cycles with en and flag high
    v(1,1,1,0, 0,0,0,0);
    v(1,1,1,0, 0,0,0,0);
    // IDLE ignores events when en=0
    v(0,0,1,0, 0,0,0,0);

    // Threshold hit: events on accepted cycles 0, 3, 7
    v(0,1,0,0, 0,0,0,0);   // IDLE -> COUNT, not counted
    v(0,1,1,0, 0,0,0,1);   // acc0
    v(0,1,0,0, 0,0,0,1);   // acc1
    v(0,1,0,0, 0,0,0,1);   // acc2
    v(0,1,1,0, 0,0,0,2);   // acc3
    v(0,1,0,0, 0,0,0,2);   // acc4
    v(0,1,0,0, 0,0,0,2);   // acc5
    v(0,1,0,0, 0,0,0,2);   // acc6
    v(0,1,1,0, 1,1,3,3);   // acc7: window end, alarm
    v(0,1,1,0, 1,0,3,3);   // alarm, flag ignored
    v(0,1,1,0, 1,0,3,3);
    v(0,1,1,0, 1,0,3,3);
    v(0,1,0,0, 0,0,3,3);   // alarm drops after 4 cycles; en=1 -> COUNT

    // Below threshold: events on accepted cycles 0 and 7
    v(0,1,1,0, 0,0,3,4);
    for (int i = 1; i < 7; i++) v(0,1,0,0, 0,0,3,4);
    v(0,1,1,0, 0,1,2,5);
    // Next window starts at once: pulse again 8 accepted cycles later
    for (int i = 0; i < 7; i++) v(0,1,0,0, 0,0,2,5);
    v(0,1,0,0, 0,1,0,5);

    // en gaps: 5-cycle gap with flag high inside the window
    v(1,0,0,0, 0,0,0,0);
    v(0,1,0,0, 0,0,0,0);   // IDLE -> COUNT
    v(0,1,1,0, 0,0,0,1);   // acc0
    v(0,1,0,0, 0,0,0,1);   // acc1
    v(0,1,0,0, 0,0,0,1);   // acc2
    v(0,1,1,0, 0,0,0,2);   // acc3
    for (int i = 0; i < 5; i++) v(0,0,1,0, 0,0,0,2);
    v(0,1,0,0, 0,0,0,2);   // acc4
    v(0,1,0,0, 0,0,0,2);   // acc5
    v(0,1,0,0, 0,0,0,2);   // acc6
    v(0,1,1,0, 1,1,3,3);   // acc7
    // Toggling en during ALARM keeps the 4-cycle length
    v(0,0,1,0, 1,0,3,3);
    v(0,1,1,0, 1,0,3,3);
    v(0,0,1,0, 1,0,3,3);
    v(0,0,1,0, 0,0,3,3);   // en=0 on last hold cycle -> IDLE
    v(0,1,1,0, 0,0,3,3);   // IDLE -> COUNT, event not counted
    v(0,1,1,0, 0,0,3,4);   // accepted

    // Clear on the window-ending cycle of the threshold-hit pattern
    v(1,0,0,0, 0,0,0,0);
    v(0,1,0,0, 0,0,0,0);
    v(0,1,1,0, 0,0,0,1);
    v(0,1,0,0, 0,0,0,1);
    v(0,1,0,0, 0,0,0,1);
    v(0,1,1,0, 0,0,0,2);
    v(0,1,0,0, 0,0,0,2);
    v(0,1,0,0, 0,0,0,2);
    v(0,1,0,0, 0,0,0,2);
    v(0,1,1,1, 0,0,0,0);   // clear wins: no pulse, no alarm, counts zero
    v(0,1,1,0, 0,0,0,0);   // IDLE -> COUNT, not counted
    // Eight events in a window, then clear during ALARM
    for (int i = 0; i < 7; i++) v(0,1,1,0, 0,0,0,16'(i + 1));
    v(0,1,1,0, 1,1,8,8);
    v(0,1,1,1, 0,0,0,0);   // clear drops alarm, zeroes last_count
    v(0,1,1,0, 0,0,0,0);   // IDLE -> COUNT
    for (int i = 0; i < 7; i++) v(0,1,1,0, 0,0,0,16'(i + 1));
    v(0,1,1,0, 1,1,8,8);
    v(1,1,1,0, 0,0,0,0);   // reset during ALARM

    for (int i = 0; i < vecs.size(); i++) begin
      reset         = vecs[i].r;
      en            = vecs[i].e;
      max_switching = vecs[i].m;
      clear         = vecs[i].c;
      @(posedge clk);
      #1;
      check("alarm",       i, 16'(alarm),       16'(vecs[i].a));
      check("window_done", i, 16'(window_done), 16'(vecs[i].w));
      check("last_count",  i, 16'(last_count),  16'(vecs[i].l));
      check("total_count", i, total_count,      vecs[i].t);
    end
    reset = 1'b0; en = 1'b0; max_switching = 1'b0; clear = 1'b0;

    // Saturation: flag and en held high on the WINDOW=256/THRESH=255 instance.
    // Each window collects 256 events; total after window k is 256*k capped.
    for (int i = 1; i <= 257; i++) begin
      exp_q.push_back((256 * i > 65535) ? 16'hFFFF : 16'(256 * i));
    end
    s_reset = 1'b1;
    @(posedge clk);
    #1;
    check("sat_reset_total", 0, s_total, 16'd0);
    s_reset = 1'b0;
    s_en    = 1'b1;
    s_ms    = 1'b1;
    k   = 0;
    cyc = 0;
    while (k < 257 && cyc < 70000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (s_wd) begin
        k++;
        want_t = exp_q.pop_front();
        check("sat_last_count",  k, 16'(s_last),  16'd255);
        check("sat_total_count", k, s_total,      want_t);
        check("sat_alarm",       k, 16'(s_alarm), 16'd1);
      end
    end
    if (k < 257) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sat_timeout: got %0d windows want 257", k);
    end
    for (int i = 0; i < 300; i++) @(posedge clk);
    #1;
    check("sat_total_hold", k, s_total, 16'hFFFF);
    s_en = 1'b0;
    s_ms = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/max_switch_monitor.md
# max_switch_monitor

Windowed monitor that sits directly downstream of the 8-bit worst-case-switching detector and consumes its 1-bit `max_switching` flag. It counts flagged cycles over fixed windows of enabled cycles. When a window reaches a threshold, it raises a registered alarm for a fixed hold period. It also keeps a saturating lifetime event count for the power/noise telemetry path.

## Interface
- `WINDOW`, 8: window length in enabled cycles; legal range 2..256.
- `THRESH`, 3: events per window that trigger the alarm; legal range 1..255.
- `HOLD`, 4: cycles the alarm stays high; legal range 1..256.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `en`  in  1  qualifies the current cycle for window counting.
- `max_switching`  in  1  worst-case-switching flag from the upstream detector, valid every cycle.
- `clear`  in  1  synchronous soft clear.
- `alarm`  out  1  high while in ALARM.
- `window_done`  out  1  one-cycle pulse after each completed window.
- `last_count`  out  8  event count of the most recently completed window.
- `total_count`  out  16  lifetime accepted events, saturating.

## Operation
- Registers:
  - `state`: IDLE, COUNT or ALARM.
  - `cyc_ctr`: 8 bits, counts 0..WINDOW-1.
  - `win_ctr`: 8 bits, saturating.
  - `hold_ctr`: 8 bits.
  - `last_count`, `total_count`, `window_done`.
- All outputs are registered: `alarm` = (state==ALARM); `window_done` is its own flop.
- Priority each edge: `reset` > `clear` > normal operation.
- `reset` or `clear`:
  - state=IDLE.
  - cyc_ctr, win_ctr, hold_ctr, last_count and total_count all 0.
  - alarm=0, window_done=0.
- IDLE:
  - Events are ignored.
  - If en=1: go to COUNT with cyc_ctr=0, win_ctr=0. The en cycle that leaves IDLE is not counted.
- COUNT, en=0: all counters frozen; `max_switching` ignored.
- COUNT, en=1 (an "accepted" cycle):
  - If max_switching=1: win_ctr += 1, saturating at 255; total_count += 1, saturating at 65535.
  - Let `n` = win_ctr including this cycle's event.
  - If cyc_ctr < WINDOW-1: cyc_ctr += 1.
  - If cyc_ctr == WINDOW-1, the window ends:
    - last_count <= n; window_done <= 1; cyc_ctr, win_ctr <= 0.
    - If n >= THRESH: go to ALARM with hold_ctr=HOLD-1.
    - Otherwise stay in COUNT and start the next window.
- `window_done` is 0 on every edge except a window end.
- ALARM:
  - Counts down HOLD cycles whether en is 1 or 0.
  - `max_switching` is ignored: no effect on win_ctr or total_count.
  - If hold_ctr != 0: hold_ctr -= 1.
  - If hold_ctr == 0:
    - en=1 in that cycle: go to COUNT with a fresh window, cyc_ctr=0, win_ctr=0.
    - en=0: go to IDLE.
- Saturation: total_count holds at 65535; win_ctr and last_count hold at 255 and cannot wrap.

## Timing
- Reset values: alarm=0, window_done=0, last_count=0, total_count=0, state=IDLE.
- First accepted cycle is one cycle after en is first sampled high in IDLE.
- `total_count` updates the edge after an accepted event (latency 1).
- Window end, for the cycle in which the WINDOW-th accepted cycle is presented:
  - Next cycle: window_done=1 and last_count valid.
  - If the threshold is met: alarm=1 in the same cycle.
- `alarm` is high for exactly HOLD consecutive cycles, then drops.
- No back-to-back ALARM: after the hold, at least WINDOW accepted cycles must pass before alarm can rise again.
- Simultaneous events:
  - An event on the last window cycle counts toward that window.
  - `clear` together with the window-ending cycle wins: no window_done, counts zeroed.
  - `reset` or `clear` during ALARM drops alarm on the next cycle.
- Disabled gaps (en=0) inside a window stretch it in wall-clock time; they do not shorten it.

## Test plan
All scenarios use the defaults (WINDOW=8, THRESH=3, HOLD=4).
- **Reset:** hold reset 2 cycles with en=1 and max_switching=1 → all outputs 0 for 2 cycles; total_count=0.
- **Threshold hit:** en=1 from cycle 0; max_switching=1 on accepted cycles 0, 3 and 7.
  - Required: window_done=1, last_count=3, alarm=1 on the cycle after accepted cycle 7.
  - alarm is high exactly 4 cycles; total_count=3.
- **Below threshold:** same as threshold hit but with events on accepted cycles 0 and 7 only.
  - Required: last_count=2, alarm stays 0, window_done pulses.
  - The next window starts immediately, giving a window_done pulse every 8 accepted cycles.
- **en gaps:** drop en for 5 cycles mid-window with max_switching=1 during the gap.
  - Required: the gap events are not counted; window_done arrives 5 cycles later than in the threshold-hit scenario.
  - During ALARM, toggling en does not change the 4-cycle alarm length.
- **Clear precedence:** assert clear on the window-ending cycle of the threshold-hit scenario.
  - Required: no window_done, no alarm, last_count=0, total_count=0.
  - Then en=1 restarts counting from IDLE.
- **Saturation:** max_switching=1 and en=1 continuously, with the parameter override THRESH=255 and WINDOW=256.
  - Required: last_count=255 at the end of each window, with no wrap.
  - After 65535 accepted events, total_count holds at 65535.
